// File: rtl/seq_looper_mc_v3_pkg.sv
// Shared types and helpers for the multi-channel sequence looper.
package seq_looper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Channel-select width never collapses to zero bits for a single channel.
  function automatic int sel_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_looper_mc_v3_if.sv
// Host-side config/control bus and pin-side outputs of the looper.
interface seq_looper_mc_v3_if
  import seq_looper_pkg::*;
#(
  parameter int NCH = 8,
  parameter int AW  = 8,
  parameter int DW  = 1,
  parameter int CW  = 32,
  parameter int LCW = 16
);
  localparam int WCW = sel_w(NCH);

  logic [NCH-1:0]        start_ch_bus;
  logic [NCH-1:0]        stop_ch_bus;
  logic                  sync_enable;
  logic [NCH-1:0]        arm_mask_in;
  logic                  arm_load;
  logic                  group_start;
  logic                  group_stop;
  logic [NCH*(AW+1)-1:0] len_bus;
  logic [NCH*CW-1:0]     rate_div_bus;
  logic [NCH*CW-1:0]     phase_off_bus;
  logic [NCH*LCW-1:0]    loop_cnt_bus;
  logic                  wr_en;
  logic [WCW-1:0]        wr_ch;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         wr_data;
  logic [NCH*DW-1:0]     io_out;
  logic [NCH-1:0]        playing;
  logic [NCH-1:0]        done_pulse;

  modport master (
    output start_ch_bus, stop_ch_bus, sync_enable, arm_mask_in, arm_load,
           group_start, group_stop, len_bus, rate_div_bus, phase_off_bus,
           loop_cnt_bus, wr_en, wr_ch, wr_addr, wr_data,
    input  io_out, playing, done_pulse
  );

  modport slave (
    input  start_ch_bus, stop_ch_bus, sync_enable, arm_mask_in, arm_load,
           group_start, group_stop, len_bus, rate_div_bus, phase_off_bus,
           loop_cnt_bus, wr_en, wr_ch, wr_addr, wr_data,
    output io_out, playing, done_pulse
  );

endinterface

// File: rtl/seq_looper_mc_v3_chan.sv
// One looper channel: pattern RAM, latched config, FSM and step/pass counters.
// Finite loop counting is built only with SEQ_LOOPER_LOOPCNT_EN.
module seq_looper_chan
  import seq_looper_pkg::*;
#(
  parameter int AW  = 8,
  parameter int DW  = 1,
  parameter int CW  = 32,
  parameter int LCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  input  logic [AW:0]    len,
  input  logic [CW-1:0]  rate_div,
  input  logic [CW-1:0]  phase_off,
`ifdef SEQ_LOOPER_LOOPCNT_EN
  input  logic [LCW-1:0] loop_cnt,
`endif
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [DW-1:0]  wr_data,
  output logic [DW-1:0]  io_out,
  output logic           playing,
  output logic           done_pulse
);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(2**AW);

  logic [DW-1:0] mem [2**AW];
  state_t        state, state_nx;
  logic [AW:0]   len_r;
  logic [CW-1:0] rate_r, cnt;
  logic [AW-1:0] addr;
  logic          load, step_end, wrap, finish;
`ifdef SEQ_LOOPER_LOOPCNT_EN
  logic [LCW-1:0] loop_r, pass;
  logic           done_r;
`endif

  function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
    if (l == '0)          return (AW+1)'(1);
    else if (l > LEN_MAX) return LEN_MAX;
    else                  return l;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step_end = 1'b0;
    wrap     = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          load     = 1'b1;
          state_nx = (phase_off != '0) ? ST_PHASE : ST_RUN;
        end
      end
      ST_PHASE: begin
        if (stop)             state_nx = ST_IDLE;
        else if (cnt == '0)   state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          state_nx = ST_IDLE;
        end else if (cnt == rate_r) begin
          step_end = 1'b1;
          if ({1'b0, addr} == len_r - 1'b1) begin
            wrap = 1'b1;
`ifdef SEQ_LOOPER_LOOPCNT_EN
            if (loop_r != '0 && pass == loop_r - 1'b1) begin
              finish   = 1'b1;
              state_nx = ST_IDLE;
            end
`endif
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // cnt counts down the start delay in PHASE and up through the step hold in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r  <= (AW+1)'(1);
      rate_r <= '0;
      cnt    <= '0;
      addr   <= '0;
    end else if (load) begin
      len_r  <= clamp_len(len);
      rate_r <= rate_div;
      cnt    <= (phase_off != '0) ? phase_off - 1'b1 : '0;
      addr   <= '0;
    end else if (state == ST_PHASE) begin
      cnt <= (cnt == '0) ? '0 : cnt - 1'b1;
    end else if (state == ST_RUN) begin
      if (step_end) begin
        cnt  <= '0;
        addr <= wrap ? '0 : addr + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef SEQ_LOOPER_LOOPCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      loop_r <= '0;
      pass   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= finish;
      if (load) begin
        loop_r <= loop_cnt;
        pass   <= '0;
      end else if (wrap) begin
        pass <= pass + 1'b1;
      end
    end
  end
  assign done_pulse = done_r;
`else
  assign done_pulse = finish;
`endif

  // Writes only land on an idle channel so a running pattern is never torn.
  always_ff @(posedge clk) begin
    if (wr_en && state == ST_IDLE) mem[wr_addr] <= wr_data;
  end

  assign playing = (state != ST_IDLE);
  assign io_out  = (state == ST_RUN) ? mem[addr] : '0;

endmodule

// File: rtl/seq_looper_mc_v3.sv
// Multi-channel looping pattern generator: arm/group control and channel array.
// Optional finite loop counting: SEQ_LOOPER_LOOPCNT_EN.
module seq_looper_mc_v3
  import seq_looper_pkg::*;
#(
  parameter int NCH = 8,
  parameter int AW  = 8,
  parameter int DW  = 1,
  parameter int CW  = 32,
  parameter int LCW = 16
) (
  input  logic             clk,
  input  logic             rst,
  seq_looper_mc_v3_if.slave bus
);
  localparam int WCW = sel_w(NCH);

  logic [NCH-1:0]    arm_reg, grp_reg, start_eff, stop_eff;
  wire  [NCH*DW-1:0] io_w;
  wire  [NCH-1:0]    playing_w, done_w;

  always_comb begin
    start_eff = bus.start_ch_bus;
    if (bus.sync_enable)
      start_eff = bus.group_start ?
                  (arm_reg | (bus.arm_load ? bus.arm_mask_in : '0)) : '0;
    stop_eff = bus.stop_ch_bus | (bus.group_stop ? grp_reg : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arm_reg <= '0;
      grp_reg <= '0;
    end else if (bus.sync_enable) begin
      if (bus.group_start) begin
        arm_reg <= '0;
        grp_reg <= start_eff;
      end else if (bus.arm_load) begin
        arm_reg <= bus.arm_mask_in;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    seq_looper_chan #(.AW(AW), .DW(DW), .CW(CW), .LCW(LCW)) u_chan (
      .clk        (clk),
      .rst        (rst),
      .start      (start_eff[i]),
      .stop       (stop_eff[i]),
      .len        (bus.len_bus[i*(AW+1) +: (AW+1)]),
      .rate_div   (bus.rate_div_bus[i*CW +: CW]),
      .phase_off  (bus.phase_off_bus[i*CW +: CW]),
`ifdef SEQ_LOOPER_LOOPCNT_EN
      .loop_cnt   (bus.loop_cnt_bus[i*LCW +: LCW]),
`endif
      .wr_en      (bus.wr_en && (bus.wr_ch == WCW'(i))),
      .wr_addr    (bus.wr_addr),
      .wr_data    (bus.wr_data),
      .io_out     (io_w[i*DW +: DW]),
      .playing    (playing_w[i]),
      .done_pulse (done_w[i])
    );
  end

  assign bus.io_out     = io_w;
  assign bus.playing    = playing_w;
  assign bus.done_pulse = done_w;

endmodule

// File: tb/tb_seq_looper_mc_v3.sv
// Directed bench for seq_looper_mc_v3: table of channel replays plus group/corner sequences.
module tb_seq_looper_mc_v3;
  localparam int NCH = 4;
  localparam int AW  = 3;
  localparam int DW  = 1;
  localparam int CW  = 8;
  localparam int LCW = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seq_looper_mc_v3_if #(.NCH(NCH), .AW(AW), .DW(DW), .CW(CW), .LCW(LCW)) bus ();

  seq_looper_mc_v3 #(.NCH(NCH), .AW(AW), .DW(DW), .CW(CW), .LCW(LCW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          ch;
    int          len;
    int          rate;
    int          ph;
    logic [7:0]  pat;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int ch, input int a, input logic d);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 2'(ch);
    bus.wr_addr = 3'(a);
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic cfg(input int ch, input int len, input int rate, input int ph, input int lc);
    bus.len_bus[ch*(AW+1) +: (AW+1)]  = (AW+1)'(len);
    bus.rate_div_bus[ch*CW +: CW]     = CW'(rate);
    bus.phase_off_bus[ch*CW +: CW]    = CW'(ph);
    bus.loop_cnt_bus[ch*LCW +: LCW]   = LCW'(lc);
  endtask

  task automatic pulse_start(input logic [NCH-1:0] m);
    bus.start_ch_bus = m;
    tick();
    bus.start_ch_bus = '0;
  endtask

  task automatic pulse_stop(input logic [NCH-1:0] m);
    bus.stop_ch_bus = m;
    tick();
    bus.stop_ch_bus = '0;
  endtask

  initial begin
    logic [15:0] got;
    logic [5:0]  got6;

    bus.start_ch_bus = '0; bus.stop_ch_bus = '0; bus.sync_enable = 1'b0;
    bus.arm_mask_in = '0; bus.arm_load = 1'b0; bus.group_start = 1'b0;
    bus.group_stop = 1'b0; bus.len_bus = '0; bus.rate_div_bus = '0;
    bus.phase_off_bus = '0; bus.loop_cnt_bus = '0; bus.wr_en = 1'b0;
    bus.wr_ch = '0; bus.wr_addr = '0; bus.wr_data = '0;
    rst = 1'b1;

    vt[0] = '{ch: 0, len: 4, rate: 1, ph: 0, pat: 8'b0000_1101, exp: 16'b1111_0011_1111_0011};
    vt[1] = '{ch: 1, len: 0, rate: 0, ph: 3, pat: 8'b0000_0001, exp: 16'b1111_1111_1111_1000};
    vt[2] = '{ch: 2, len: 3, rate: 0, ph: 1, pat: 8'b0000_0110, exp: 16'b1101_1011_0110_1100};
    vt[3] = '{ch: 3, len: 9, rate: 0, ph: 0, pat: 8'b1100_1010, exp: 16'b1100_1010_1100_1010};

    tick(); tick();
    chk("reset_io", 32'(bus.io_out), 0);
    chk("reset_playing", 32'(bus.playing), 0);
    chk("reset_done", 32'(bus.done_pulse), 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      for (int a = 0; a < 8; a++) wr(vt[v].ch, a, vt[v].pat[a]);
      cfg(vt[v].ch, vt[v].len, vt[v].rate, vt[v].ph, 0);
      pulse_start(4'(1 << vt[v].ch));
      chk($sformatf("v%0d_playing_t1", v), 32'(bus.playing[vt[v].ch]), 1);
      for (int k = 0; k < 16; k++) begin
        got[k] = bus.io_out[vt[v].ch];
        tick();
      end
      chk($sformatf("v%0d_io_seq", v), 32'(got), 32'(vt[v].exp));
      pulse_stop(4'(1 << vt[v].ch));
      chk($sformatf("v%0d_stop_playing", v), 32'(bus.playing), 0);
      chk($sformatf("v%0d_stop_io", v), 32'(bus.io_out), 0);
    end

    // start and stop together on idle ch3
    bus.start_ch_bus = 4'b1000;
    bus.stop_ch_bus  = 4'b1000;
    tick();
    bus.start_ch_bus = '0;
    bus.stop_ch_bus  = '0;
    chk("start_stop_same", 32'(bus.playing), 0);

    // write to playing ch3 is dropped
    pulse_start(4'b1000);
    wr(3, 0, 1'b1);
    pulse_stop(4'b1000);
    pulse_start(4'b1000);
    chk("write_dropped", 32'(bus.io_out[3]), 0);
    pulse_stop(4'b1000);

    // write and start in the same cycle replays the new value
    bus.wr_en = 1'b1; bus.wr_ch = 2'd3; bus.wr_addr = 3'd0; bus.wr_data = 1'b1;
    bus.start_ch_bus = 4'b1000;
    tick();
    bus.wr_en = 1'b0; bus.start_ch_bus = '0;
    chk("write_with_start", 32'(bus.io_out[3]), 1);
    pulse_stop(4'b1000);

    // group control: ch1 independent, then ch0+ch2 as a group
    pulse_start(4'b0010);
    bus.sync_enable = 1'b1;
    bus.start_ch_bus = 4'b1000;
    tick();
    bus.start_ch_bus = '0;
    chk("sync_ignores_start_ch", 32'(bus.playing), 32'h2);
    bus.arm_mask_in = 4'b0101; bus.arm_load = 1'b1; bus.group_start = 1'b1;
    tick();
    bus.arm_load = 1'b0; bus.group_start = 1'b0;
    chk("group_start_same_arm", 32'(bus.playing), 32'h7);
    bus.group_stop = 1'b1;
    tick();
    bus.group_stop = 1'b0;
    chk("group_stop", 32'(bus.playing), 32'h2);
    bus.group_start = 1'b1;
    tick();
    bus.group_start = 1'b0;
    chk("group_start_no_arm", 32'(bus.playing), 32'h2);
    bus.arm_mask_in = 4'b1000; bus.arm_load = 1'b1;
    tick();
    bus.arm_load = 1'b0;
    chk("arm_only", 32'(bus.playing), 32'h2);
    bus.group_start = 1'b1;
    tick();
    bus.group_start = 1'b0;
    chk("group_start_armed", 32'(bus.playing), 32'hA);
    pulse_stop(4'b1111);
    chk("stop_all", 32'(bus.playing), 0);
    bus.sync_enable = 1'b0;

    // loop count: ch0 pattern 1,0,1, two passes
    cfg(0, 3, 0, 0, 2);
    pulse_start(4'b0001);
    for (int k = 0; k < 6; k++) begin
      got6[k] = bus.io_out[0];
      if (k < 5) tick();
    end
    chk("loop_seq", 32'(got6), 32'b101_101);
    chk("loop_last_playing", 32'(bus.playing[0]), 1);
    tick();
`ifdef SEQ_LOOPER_LOOPCNT_EN
    chk("loop_end_playing", 32'(bus.playing[0]), 0);
    chk("loop_done", 32'(bus.done_pulse), 32'h1);
    tick();
    chk("loop_done_once", 32'(bus.done_pulse), 0);
`else
    chk("loop_infinite_playing", 32'(bus.playing[0]), 1);
    chk("loop_no_done", 32'(bus.done_pulse), 0);
    pulse_stop(4'b0001);
`endif

    // reset mid-run
    cfg(0, 4, 1, 0, 0);
    pulse_start(4'b0111);
    chk("pre_reset_playing", 32'(bus.playing), 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_reset_io", 32'(bus.io_out), 0);
    chk("midrun_reset_playing", 32'(bus.playing), 0);
    chk("midrun_reset_done", 32'(bus.done_pulse), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
